flash_mp_op_gate: RTL and testbench

- Sequences one flash controller operation (read, program, page erase, bank erase) word by word toward the flash phy.
- Drives the request/page inputs of the data-region selector and consumes its selected region configuration (mp_region_cfg_t).
- Permission is re-checked on the first word and on every page crossing.
- Denied or timed-out operations are aborted with an error pulse and the faulting address.

---
 rtl/flash_mp_op_gate.sv | 218 +++++++++++++++++++++
 tb/tb_flash_mp_op_gate.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_mp_op_gate.sv
// Flash memory-protection operation gate: sequences one read/prog/erase op toward the phy,
// re-checking region permission per page. Optional macro FLASH_MP_ERR_CNT_EN builds a saturating error counter.
package flash_mp_pkg;
    typedef struct packed {
        logic q;
    } cfg_bit_t;

    typedef struct packed {
        cfg_bit_t en;
        cfg_bit_t rd_en;
        cfg_bit_t prog_en;
        cfg_bit_t erase_en;
        cfg_bit_t scramble_en;
        cfg_bit_t ecc_en;
    } mp_region_cfg_t;
endpackage

module flash_mp_op_gate
    import flash_mp_pkg::*;
#(
    parameter int AllPagesW     = 4,
    parameter int PageWordsW    = 8,
    parameter int CntW          = 12,
    parameter int TimeoutCycles = 1024,
    localparam int AddrW        = AllPagesW + PageWordsW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    output logic                 ack_o,
    input  logic [1:0]           op_i,
    input  logic [AddrW-1:0]     addr_i,
    input  logic [CntW-1:0]      num_words_i,
    output logic                 mp_req_o,
    output logic [AllPagesW-1:0] mp_page_o,
    input  mp_region_cfg_t       sel_cfg_i,
    input  mp_region_cfg_t       default_cfg_i,
    output logic                 phy_req_o,
    output logic [1:0]           phy_op_o,
    output logic [AddrW-1:0]     phy_addr_o,
    output logic                 phy_scramble_en_o,
    output logic                 phy_ecc_en_o,
    input  logic                 phy_done_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 err_timeout_o,
    output logic [AddrW-1:0]     err_addr_o,
    output logic [7:0]           err_cnt_o
);

    localparam int TimerW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    localparam logic [TimerW-1:0] TimerMax = TimerW'(TimeoutCycles - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StCheck = 3'd1;
    localparam logic [2:0] StIssue = 3'd2;
    localparam logic [2:0] StErr   = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [AddrW-1:0]  cur_addr_q, cur_addr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [CntW-1:0]   word_idx_q, word_idx_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              scramble_q, scramble_d;
    logic              ecc_q, ecc_d;
    logic              timeout_q, timeout_d;
    logic [AddrW-1:0]  err_addr_q, err_addr_d;

    mp_region_cfg_t    eff_cfg;
    logic              allowed;
    logic [AddrW-1:0]  next_addr;
    logic [PageWordsW-1:0] next_word_in_page;
    logic              unused_default_en;

    assign unused_default_en = default_cfg_i.en.q;
    assign eff_cfg   = sel_cfg_i.en.q ? sel_cfg_i : default_cfg_i;
    assign next_addr = cur_addr_q + AddrW'(1);
    assign next_word_in_page = next_addr[PageWordsW-1:0];

    // Bank erase covers every region, so only the default permission applies.
    always_comb begin
        case (op_q)
            2'd0:    allowed = eff_cfg.rd_en.q;
            2'd1:    allowed = eff_cfg.prog_en.q;
            2'd2:    allowed = eff_cfg.erase_en.q;
            default: allowed = default_cfg_i.erase_en.q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cur_addr_d = cur_addr_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        timer_d    = timer_q;
        scramble_d = scramble_q;
        ecc_d      = ecc_q;
        timeout_d  = timeout_q;
        err_addr_d = err_addr_q;

        case (state_q)
            StIdle: begin
                if (req_i) begin
                    op_d       = op_i;
                    cur_addr_d = addr_i;
                    count_d    = num_words_i;
                    word_idx_d = '0;
                    timer_d    = '0;
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                if (allowed) begin
                    scramble_d = eff_cfg.scramble_en.q;
                    ecc_d      = eff_cfg.ecc_en.q;
                    timer_d    = '0;
                    state_d    = StIssue;
                end else begin
                    timeout_d  = 1'b0;
                    err_addr_d = cur_addr_q;
                    state_d    = StErr;
                end
            end
            StIssue: begin
                // A completion in the same cycle as the timer limit wins over the timeout.
                if (phy_done_i) begin
                    if (op_q[1] || (word_idx_q == count_q)) begin
                        state_d = StDone;
                    end else begin
                        cur_addr_d = next_addr;
                        word_idx_d = word_idx_q + CntW'(1);
                        timer_d    = '0;
                        if (next_word_in_page == '0) begin
                            state_d = StCheck;
                        end
                    end
                end else if (timer_q == TimerMax) begin
                    timeout_d  = 1'b1;
                    err_addr_d = cur_addr_q;
                    state_d    = StErr;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StErr:   state_d = StIdle;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            op_q       <= '0;
            cur_addr_q <= '0;
            count_q    <= '0;
            word_idx_q <= '0;
            timer_q    <= '0;
            scramble_q <= 1'b0;
            ecc_q      <= 1'b0;
            timeout_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cur_addr_q <= cur_addr_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            timer_q    <= timer_d;
            scramble_q <= scramble_d;
            ecc_q      <= ecc_d;
            timeout_q  <= timeout_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign ack_o             = (state_q == StIdle) && req_i;
    assign busy_o            = (state_q != StIdle);
    assign mp_req_o          = (state_q == StCheck);
    assign mp_page_o         = cur_addr_q[AddrW-1:PageWordsW];
    assign phy_req_o         = (state_q == StIssue);
    assign phy_op_o          = op_q;
    assign phy_addr_o        = cur_addr_q;
    assign phy_scramble_en_o = scramble_q;
    assign phy_ecc_en_o      = ecc_q;
    assign done_o            = (state_q == StDone);
    assign err_o             = (state_q == StErr);
    assign err_timeout_o     = (state_q == StErr) && timeout_q;
    assign err_addr_o        = err_addr_q;

`ifdef FLASH_MP_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_o && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_flash_mp_op_gate.sv
// Directed self-checking bench for flash_mp_op_gate (TimeoutCycles = 16, 12-bit word address).
module tb_flash_mp_op_gate;
    import flash_mp_pkg::*;

    localparam int AllPagesW     = 4;
    localparam int PageWordsW    = 8;
    localparam int CntW          = 12;
    localparam int TimeoutCycles = 16;
    localparam int AddrW         = AllPagesW + PageWordsW;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 req_i;
    logic                 ack_o;
    logic [1:0]           op_i;
    logic [AddrW-1:0]     addr_i;
    logic [CntW-1:0]      num_words_i;
    logic                 mp_req_o;
    logic [AllPagesW-1:0] mp_page_o;
    mp_region_cfg_t       sel_cfg_i;
    mp_region_cfg_t       default_cfg_i;
    logic                 phy_req_o;
    logic [1:0]           phy_op_o;
    logic [AddrW-1:0]     phy_addr_o;
    logic                 phy_scramble_en_o;
    logic                 phy_ecc_en_o;
    logic                 phy_done_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;
    logic                 err_timeout_o;
    logic [AddrW-1:0]     err_addr_o;
    logic [7:0]           err_cnt_o;

    // Stand-in for the region selector: optionally only page 0 matches the region.
    mp_region_cfg_t regionCfg;
    logic           pageGated;

    always_comb begin
        sel_cfg_i = regionCfg;
        if (pageGated && (mp_page_o != '0)) begin
            sel_cfg_i = '0;
        end
    end

    always #5 clk_i = ~clk_i;

    flash_mp_op_gate #(
        .AllPagesW    (AllPagesW),
        .PageWordsW   (PageWordsW),
        .CntW         (CntW),
        .TimeoutCycles(TimeoutCycles)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_i            (req_i),
        .ack_o            (ack_o),
        .op_i             (op_i),
        .addr_i           (addr_i),
        .num_words_i      (num_words_i),
        .mp_req_o         (mp_req_o),
        .mp_page_o        (mp_page_o),
        .sel_cfg_i        (sel_cfg_i),
        .default_cfg_i    (default_cfg_i),
        .phy_req_o        (phy_req_o),
        .phy_op_o         (phy_op_o),
        .phy_addr_o       (phy_addr_o),
        .phy_scramble_en_o(phy_scramble_en_o),
        .phy_ecc_en_o     (phy_ecc_en_o),
        .phy_done_i       (phy_done_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o),
        .err_timeout_o    (err_timeout_o),
        .err_addr_o       (err_addr_o),
        .err_cnt_o        (err_cnt_o)
    );

    int assertCount = 0;
    int failCount   = 0;
    int errTotal    = 0;

    // Per-operation observations gathered by applyStimulus.
    logic             ackSeen;
    logic             finished;
    int               doneCnt;
    int               errCnt;
    int               errCycle;
    int               firstIssueCycle;
    int               phyReqCycles;
    int               mpReqCycles;
    logic [AddrW-1:0] wordAddr[$];
    logic [AddrW-1:0] lastErrAddr;
    logic             lastErrTimeout;
    logic             scrAtDone;
    logic             eccAtDone;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic mp_region_cfg_t mkCfg(input logic en, input logic rd, input logic pr,
                                             input logic er, input logic scr, input logic ecc);
        mp_region_cfg_t c;
        c.en.q          = en;
        c.rd_en.q       = rd;
        c.prog_en.q     = pr;
        c.erase_en.q    = er;
        c.scramble_en.q = scr;
        c.ecc_en.q      = ecc;
        return c;
    endfunction

    function automatic int expectedErrCnt(input int total);
`ifdef FLASH_MP_ERR_CNT_EN
        return (total > 255) ? 255 : total;
`else
        return 0;
`endif
    endfunction

    // Issues one request, then plays the phy: a phy_done_i every 'period' issue cycles (0 = never).
    // Cycle 0 is the ack cycle; observations stop at done_o/err_o or after 'budget' cycles.
    task automatic applyStimulus(input logic [1:0] op, input logic [AddrW-1:0] addr,
                                 input logic [CntW-1:0] num, input int period, input int budget);
        int waitCnt;
        ackSeen = 0; finished = 0; doneCnt = 0; errCnt = 0; errCycle = -1;
        firstIssueCycle = -1; phyReqCycles = 0; mpReqCycles = 0;
        lastErrAddr = '0; lastErrTimeout = 0; scrAtDone = 0; eccAtDone = 0;
        wordAddr.delete();
        waitCnt = 0;
        @(negedge clk_i);
        op_i = op; addr_i = addr; num_words_i = num; req_i = 1'b1;
        #1 ackSeen = ack_o;
        @(negedge clk_i);
        req_i = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            phy_done_i = 1'b0;
            if (phy_req_o) begin
                phyReqCycles++;
                if (firstIssueCycle < 0) firstIssueCycle = c;
                waitCnt++;
                if (period > 0 && waitCnt == period) begin
                    phy_done_i = 1'b1;
                    wordAddr.push_back(phy_addr_o);
                    scrAtDone = phy_scramble_en_o;
                    eccAtDone = phy_ecc_en_o;
                    waitCnt = 0;
                end
            end
            #1;
            if (mp_req_o) mpReqCycles++;
            if (done_o) begin
                doneCnt++;
                finished = 1;
            end
            if (err_o) begin
                errCnt++;
                errTotal++;
                errCycle = c;
                lastErrAddr = err_addr_o;
                lastErrTimeout = err_timeout_o;
                finished = 1;
            end
            if (finished) break;
            @(negedge clk_i);
        end
        phy_done_i = 1'b0;
        checkOutput("opFinishedInBudget", 32'(finished), 32'd1);
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        int satErrs;
        rst_i = 1'b1; req_i = 1'b0; op_i = '0; addr_i = '0; num_words_i = '0;
        phy_done_i = 1'b0; pageGated = 1'b0;
        regionCfg = '0; default_cfg_i = '0;

        // Reset state
        @(negedge clk_i);
        #1;
        checkOutput("resetOutputs",
                    {ack_o, mp_req_o, phy_req_o, busy_o, done_o, err_o, err_timeout_o,
                     phy_scramble_en_o, phy_ecc_en_o, phy_op_o, phy_addr_o, err_addr_o},
                    32'd0);
        checkOutput("resetErrCnt", 32'(err_cnt_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Read 4 words at 0x010 with a matching region (scramble on, ecc off)
        regionCfg = mkCfg(1, 1, 0, 0, 1, 0);
        applyStimulus(2'd0, 12'h010, 12'd3, 2, 40);
        checkOutput("rdAck", 32'(ackSeen), 32'd1);
        checkOutput("rdWords", 32'(wordAddr.size()), 32'd4);
        for (int i = 0; i < 4 && i < wordAddr.size(); i++) begin
            checkOutput($sformatf("rdAddr%0d", i), 32'(wordAddr[i]), 32'h010 + 32'(i));
        end
        checkOutput("rdDone", 32'(doneCnt), 32'd1);
        checkOutput("rdErr", 32'(errCnt), 32'd0);
        checkOutput("rdDoneCycle", 32'(errCycle), 32'hFFFF_FFFF);
        checkOutput("rdMpReqCycles", 32'(mpReqCycles), 32'd1);
        checkOutput("rdScramble", 32'(scrAtDone), 32'd1);
        checkOutput("rdEcc", 32'(eccAtDone), 32'd0);
        checkOutput("rdIdleAfter", {30'd0, phy_req_o, busy_o}, 32'd0);

        // Program across a page boundary into a page with no region and no default permission
        regionCfg = mkCfg(1, 0, 1, 0, 0, 1);
        pageGated = 1'b1;
        default_cfg_i = mkCfg(0, 1, 0, 1, 0, 0);
        applyStimulus(2'd1, 12'h0FE, 12'd3, 1, 40);
        checkOutput("prWords", 32'(wordAddr.size()), 32'd2);
        checkOutput("prErr", 32'(errCnt), 32'd1);
        checkOutput("prDone", 32'(doneCnt), 32'd0);
        checkOutput("prErrAddr", 32'(lastErrAddr), 32'h100);
        checkOutput("prErrTimeout", 32'(lastErrTimeout), 32'd0);
        checkOutput("prMpReqCycles", 32'(mpReqCycles), 32'd2);
        checkOutput("prErrAddrHeld", 32'(err_addr_o), 32'h100);
        pageGated = 1'b0;

        // Page erase via default permission: one completion ends the op
        regionCfg = mkCfg(0, 1, 1, 0, 0, 0);
        default_cfg_i = mkCfg(0, 0, 0, 1, 0, 0);
        applyStimulus(2'd2, 12'h345, 12'd7, 1, 20);
        checkOutput("peWords", 32'(wordAddr.size()), 32'd1);
        checkOutput("peDone", 32'(doneCnt), 32'd1);

        // Page erase denied: err two cycles after ack, phy never requested
        default_cfg_i = mkCfg(0, 1, 1, 0, 0, 0);
        applyStimulus(2'd2, 12'h345, 12'd0, 1, 20);
        checkOutput("peDenyErrCycle", 32'(errCycle), 32'd2);
        checkOutput("peDenyPhyReq", 32'(phyReqCycles), 32'd0);
        checkOutput("peDenyErrAddr", 32'(lastErrAddr), 32'h345);
        checkOutput("errCntAfterDeny", 32'(err_cnt_o), 32'(expectedErrCnt(errTotal)));

        // Bank erase ignores an enabled region and uses only the default
        regionCfg = mkCfg(1, 0, 0, 1, 0, 0);
        default_cfg_i = mkCfg(0, 0, 0, 0, 0, 0);
        applyStimulus(2'd3, 12'h200, 12'd0, 1, 20);
        checkOutput("beDenyErr", 32'(errCnt), 32'd1);
        regionCfg = mkCfg(1, 1, 1, 0, 0, 0);
        default_cfg_i = mkCfg(0, 0, 0, 1, 0, 0);
        applyStimulus(2'd3, 12'h200, 12'd0, 1, 20);
        checkOutput("beAllowDone", 32'(doneCnt), 32'd1);

        // Timeout: no completion ever, err 16 cycles after first issue cycle
        regionCfg = mkCfg(1, 1, 0, 0, 0, 0);
        applyStimulus(2'd0, 12'h055, 12'd3, 0, 60);
        checkOutput("toErr", 32'(errCnt), 32'd1);
        checkOutput("toTimeoutFlag", 32'(lastErrTimeout), 32'd1);
        checkOutput("toLatency", 32'(errCycle - firstIssueCycle), 32'd16);
        checkOutput("toErrAddr", 32'(lastErrAddr), 32'h055);

        // Address wrap from 0xFFF to 0x000 is a page crossing and is rechecked
        applyStimulus(2'd0, 12'hFFF, 12'd1, 1, 20);
        checkOutput("wrapDone", 32'(doneCnt), 32'd1);
        checkOutput("wrapMpReqCycles", 32'(mpReqCycles), 32'd2);
        checkOutput("wrapWords", 32'(wordAddr.size()), 32'd2);
        if (wordAddr.size() == 2) checkOutput("wrapAddr1", 32'(wordAddr[1]), 32'h000);

        // Reset in the middle of a 10-word read
        @(negedge clk_i);
        op_i = 2'd0; addr_i = 12'h020; num_words_i = 12'd9; req_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1 checkOutput("midOpBusy", {30'd0, phy_req_o, busy_o}, 32'd3);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checkOutput("midResetOutputs",
                    {ack_o, mp_req_o, phy_req_o, busy_o, done_o, err_o, err_timeout_o,
                     phy_op_o, phy_addr_o, err_addr_o},
                    32'd0);
        checkOutput("midResetErrCnt", 32'(err_cnt_o), 32'd0);
        errTotal = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        satErrs = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            #1 if (done_o || err_o) satErrs++;
        end
        checkOutput("postResetQuiet", 32'(satErrs), 32'd0);
        applyStimulus(2'd0, 12'h020, 12'd1, 1, 20);
        checkOutput("postResetDone", 32'(doneCnt), 32'd1);
        checkOutput("postResetWords", 32'(wordAddr.size()), 32'd2);

        // 300 back-to-back denied requests drive the error counter into saturation
        regionCfg = mkCfg(0, 0, 0, 0, 0, 0);
        default_cfg_i = mkCfg(0, 0, 0, 0, 0, 0);
        satErrs = 0;
        @(negedge clk_i);
        op_i = 2'd2; addr_i = 12'h400; req_i = 1'b1;
        for (int c = 0; c < 1500 && satErrs < 300; c++) begin
            @(negedge clk_i);
            #1 if (err_o) satErrs++;
        end
        req_i = 1'b0;
        errTotal += satErrs;
        repeat (3) @(negedge clk_i);
        #1;
        checkOutput("satErrPulses", 32'(satErrs), 32'd300);
        checkOutput("satErrCnt", 32'(err_cnt_o), 32'(expectedErrCnt(errTotal)));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
